// File: rtl/mem_responder.sv
// mem_responder: CPU-side word RAM plus MMIO page (LEDs, 8N1 UART transmitter, cycle counter).
// Define MEM_UART_FIFO_EN to put a 4-entry TX FIFO in front of the UART state machine.
module mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter     INIT_FILE = "",
  parameter int IO_BIT    = 22,
  parameter int LED_W     = 5,
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 115200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wmask,
  input  logic             mem_rstrb,
  output logic [31:0]      mem_rdata,
  output logic [LED_W-1:0] leds,
  output logic             uart_tx
);
  localparam int          AW     = $clog2(MEM_WORDS);
  localparam logic [31:0] DIV_M1 = 32'(CLK_HZ / BAUD - 1);

  // state   | meaning
  // S_IDLE  | line idle high, waiting for a byte
  // S_START | start bit (low) for DIV cycles
  // S_DATA  | 8 data bits, LSB first, DIV cycles each
  // S_STOP  | stop bit (high) for DIV cycles
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic [31:0]      r_ram [MEM_WORDS];
  logic [31:0]      r_rdata;
  logic [LED_W-1:0] r_leds;
  logic [31:0]      r_cycles;

  uart_state_t      r_state, w_state_nxt;
  logic [31:0]      r_div, w_div_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_sh, w_sh_nxt;
  logic             r_uart_tx, w_tx_nxt;

  logic             w_io, w_wr, w_tx_wr, w_busy, w_tx_accept;
  logic             w_div_zero, w_idle_load, w_chain_load;
  logic [7:0]       w_idle_data, w_chain_data;
  logic [AW-1:0]    w_idx;
  logic [1:0]       w_off;
  logic             w_unused;

  assign w_io       = mem_addr[IO_BIT];
  assign w_idx      = mem_addr[AW+1:2];
  assign w_off      = mem_addr[3:2];
  assign w_wr       = |mem_wmask;
  assign w_tx_wr    = w_io & w_wr & (w_off == 2'd1);
  assign w_div_zero = (r_div == 32'd0);
  assign w_unused   = ^{mem_addr, mem_wdata};

`ifdef MEM_UART_FIFO_EN
  // The byte on the wire stays at the FIFO head until its stop bit ends.
  logic [7:0] r_fifo [4];
  logic [1:0] r_rd_ptr, r_wr_ptr, w_rd_next;
  logic [2:0] r_count;
  logic       w_pop;

  assign w_pop        = (r_state == S_STOP) & w_div_zero;
  assign w_busy       = (r_count == 3'd4);
  assign w_tx_accept  = w_tx_wr & (~w_busy | w_pop);
  assign w_rd_next    = r_rd_ptr + 2'd1;
  assign w_idle_load  = (r_count != 3'd0) | w_tx_accept;
  assign w_idle_data  = (r_count != 3'd0) ? r_fifo[r_rd_ptr] : mem_wdata[7:0];
  assign w_chain_load = w_pop & ((r_count > 3'd1) | w_tx_accept);
  assign w_chain_data = (r_count > 3'd1) ? r_fifo[w_rd_next] : mem_wdata[7:0];

  always_ff @(posedge clk) begin
    if (w_tx_accept) r_fifo[r_wr_ptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_tx_accept) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)       r_rd_ptr <= w_rd_next;
      r_count <= r_count + {2'b00, w_tx_accept} - {2'b00, w_pop};
    end
  end
`else
  assign w_busy       = (r_state != S_IDLE);
  assign w_tx_accept  = w_tx_wr & ~w_busy;
  assign w_idle_load  = w_tx_accept;
  assign w_idle_data  = mem_wdata[7:0];
  assign w_chain_load = 1'b0;
  assign w_chain_data = 8'h00;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_sh_nxt    = r_sh;
    unique case (r_state)
      S_IDLE: begin
        if (w_idle_load) begin
          w_state_nxt = S_START;
          w_div_nxt   = DIV_M1;
          w_sh_nxt    = w_idle_data;
        end
      end
      S_START: begin
        if (w_div_zero) begin
          w_state_nxt = S_DATA;
          w_div_nxt   = DIV_M1;
          w_bit_nxt   = 3'd0;
        end else begin
          w_div_nxt = r_div - 32'd1;
        end
      end
      S_DATA: begin
        if (w_div_zero) begin
          w_div_nxt = DIV_M1;
          w_sh_nxt  = r_sh >> 1;
          w_bit_nxt = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
        end else begin
          w_div_nxt = r_div - 32'd1;
        end
      end
      S_STOP: begin
        if (w_div_zero) begin
          if (w_chain_load) begin
            w_state_nxt = S_START;
            w_div_nxt   = DIV_M1;
            w_sh_nxt    = w_chain_data;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_div_nxt = r_div - 32'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // The line level is registered from the next state so uart_tx never glitches.
    w_tx_nxt = 1'b1;
    if (w_state_nxt == S_START)     w_tx_nxt = 1'b0;
    else if (w_state_nxt == S_DATA) w_tx_nxt = w_sh_nxt[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_sh      <= '0;
      r_uart_tx <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_bit     <= w_bit_nxt;
      r_sh      <= w_sh_nxt;
      r_uart_tx <= w_tx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_io) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wmask[i]) r_ram[w_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Reads sample the RAM before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (mem_rstrb) begin
      if (!w_io) begin
        r_rdata <= r_ram[w_idx];
      end else begin
        unique case (w_off)
          2'd0:    r_rdata <= 32'(r_leds);
          2'd1:    r_rdata <= '0;
          2'd2:    r_rdata <= {31'd0, w_busy};
          default: r_rdata <= r_cycles;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_leds   <= '0;
      r_cycles <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (w_io & w_wr & (w_off == 2'd0)) r_leds <= mem_wdata[LED_W-1:0];
    end
  end

  assign mem_rdata = r_rdata;
  assign leds      = r_leds;
  assign uart_tx   = r_uart_tx;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a frame-level reference model predicts reads, LEDs and the
// UART line; a negedge monitor compares. Follows MEM_UART_FIFO_EN when it is defined.
`timescale 1ns/1ps
module tb_mem_responder;
  localparam int MW  = 64;
  localparam int AW  = 6;
  localparam int IOB = 22;
  localparam int LW  = 5;
  localparam int DIV = 8;
  localparam int FR  = 10 * DIV;
`ifdef MEM_UART_FIFO_EN
  localparam int CAP        = 4;
  localparam bit POP_BYPASS = 1'b1;
`else
  localparam int CAP        = 1;
  localparam bit POP_BYPASS = 1'b0;
`endif
  localparam logic [31:0] IO = 32'h0040_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wmask = '0;
  logic          mem_rstrb = 1'b0;
  logic [31:0]   mem_rdata;
  logic [LW-1:0] leds;
  logic          uart_tx;

  mem_responder #(
    .MEM_WORDS(MW), .IO_BIT(IOB), .LED_W(LW), .CLK_HZ(8), .BAUD(1)
  ) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .leds(leds), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  // A frame is accepted at edge acc and occupies cycles start .. start+FR-1 on the line.
  typedef struct {int acc; int start; logic [7:0] data;} frame_t;
  frame_t        frames[$];
  logic [31:0]   m_ram [MW];
  logic [LW-1:0] m_leds;
  logic [31:0]   m_cycles;
  logic [31:0]   exp_rd[$];
  int            edge_n = 0;
  bit            mon_en = 1'b0;
  int            n_chk = 0;
  int            n_pass = 0;

  function automatic int occ(input int c);
    int n = 0;
    foreach (frames[i]) if (frames[i].acc <= c && c < frames[i].start + FR) n++;
    return n;
  endfunction

  function automatic bit ends_at(input int k);
    foreach (frames[i]) if (frames[i].start + FR == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic tx_at(input int c);
    int b;
    foreach (frames[i]) begin
      if (c >= frames[i].start && c < frames[i].start + FR) begin
        b = (c - frames[i].start) / DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return frames[i].data[b-1];
      end
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    int          k;
    int          st;
    logic [31:0] e;
    edge_n++;
    k = edge_n;
    if (rst) begin
      frames.delete();
      m_leds   = '0;
      m_cycles = '0;
      exp_rd.push_back(32'd0);
      mon_en   = 1'b1;
    end else begin
      if (mem_rstrb) begin
        if (!mem_addr[IOB]) e = m_ram[mem_addr[AW+1:2]];
        else case (mem_addr[3:2])
          2'd0:    e = 32'(m_leds);
          2'd1:    e = 32'd0;
          2'd2:    e = {31'd0, occ(k-1) >= CAP};
          default: e = m_cycles;
        endcase
        exp_rd.push_back(e);
      end
      if (mem_wmask != 4'd0) begin
        if (!mem_addr[IOB]) begin
          for (int i = 0; i < 4; i++)
            if (mem_wmask[i]) m_ram[mem_addr[AW+1:2]][8*i +: 8] = mem_wdata[8*i +: 8];
        end else if (mem_addr[3:2] == 2'd0) begin
          m_leds = mem_wdata[LW-1:0];
        end else if (mem_addr[3:2] == 2'd1) begin
          if (occ(k-1) < CAP || (POP_BYPASS && ends_at(k))) begin
            st = k;
            if (frames.size() > 0 && frames[$].start + FR > st) st = frames[$].start + FR;
            frames.push_back('{k, st, mem_wdata[7:0]});
          end
        end
      end
      m_cycles = m_cycles + 32'd1;
      while (frames.size() > 0 && frames[0].start + FR < k) void'(frames.pop_front());
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_n, act, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("uart_tx", 32'(uart_tx), 32'(tx_at(edge_n)));
      chk("leds", 32'(leds), 32'(m_leds));
      if (exp_rd.size() > 0) chk("rdata", mem_rdata, exp_rd.pop_front());
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic s);
    @(posedge clk);
    #1;
    rst = 1'b0; mem_addr = a; mem_wdata = d; mem_wmask = m; mem_rstrb = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(IO | 32'h8, 32'd0, 4'h0, (i % 5) == 0);
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    rst = 1'b1; mem_addr = '0; mem_wdata = '0; mem_wmask = '0; mem_rstrb = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        s;
    repeat (3) @(posedge clk);
    for (int i = 0; i < MW; i++) drive(32'(i * 4), $urandom, 4'hF, 1'b0);
    for (int i = 0; i < MW; i++) begin
      a = $urandom;
      a[IOB] = 1'b0;
      a[AW+1:2] = AW'(i);
      drive(a, 32'd0, 4'h0, 1'b1);
    end
    drive(32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    drive(32'h10, 32'd0, 4'h0, 1'b1);
    drive(32'h10, 32'h00AA0000, 4'b0100, 1'b0);
    drive(32'h10, 32'd0, 4'h0, 1'b1);
    drive(32'h14, 32'd0, 4'h0, 1'b1);
    drive(32'(MW * 4) + 32'h10, 32'h1, 4'hF, 1'b0);
    drive(32'h10, 32'd0, 4'h0, 1'b1);
    drive(32'h20, 32'h12345678, 4'hF, 1'b1);
    drive(32'h20, 32'd0, 4'h0, 1'b1);
    drive(IO, 32'h1F, 4'hF, 1'b0);
    drive(IO, 32'd0, 4'h0, 1'b1);
    drive(IO | 32'hC, 32'd0, 4'h0, 1'b1);
    drive(IO | 32'hC, 32'd0, 4'h0, 1'b1);
    reset_cycle();
    drive(IO, 32'd0, 4'h0, 1'b1);
    drive(IO | 32'h4, 32'hA5, 4'h1, 1'b0);
    for (int i = 0; i < 95; i++)
      drive((i == 20) ? (IO | 32'h4) : (IO | 32'h8), 32'h3C, (i == 20) ? 4'h1 : 4'h0, 1'b1);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset_cycle();
      end else begin
        a = $urandom;
        d = $urandom;
        s = ($urandom_range(0, 99) < 40);
        a[IOB] = ($urandom_range(0, 1) == 1);
        m = ($urandom_range(0, 99) < 30) ? 4'($urandom_range(1, 15)) : 4'h0;
        drive(a, d, m, s);
      end
    end
    idle(420);
    for (int i = 0; i < 5; i++) drive(IO | 32'h4, 32'(i + 1), 4'h1, 1'b1);
    idle(100);
    reset_cycle();
    idle(400);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
